// File: rtl/lcd_bus_arbiter.sv
// Round-robin arbiter that serialises byte writes from NREQ requesters onto an HD44780-style LCD bus.
// Each write is a timed bus cycle: setup, E pulse, hold, then a busy wait that is long for clear/home.
module lcd_bus_arbiter #(
  parameter int NREQ       = 2,
  parameter int SETUP_CYC  = 1,
  parameter int E_HIGH_CYC = 2,
  parameter int WAIT_SHORT = 4,
  parameter int WAIT_LONG  = 160
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              init_done,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ-1:0]   req_rs,
  input  logic [8*NREQ-1:0] req_data,
  output logic [NREQ-1:0]   gnt,
  output logic [NREQ-1:0]   done,
  output logic              busy,
  output logic              RS,
  output logic              RW,
  output logic              E,
  output logic [7:0]        DB
);

  localparam int SU_EFF = (SETUP_CYC  < 1) ? 1 : SETUP_CYC;
  localparam int EH_EFF = (E_HIGH_CYC < 1) ? 1 : E_HIGH_CYC;
  localparam int WS_EFF = (WAIT_SHORT < 1) ? 1 : WAIT_SHORT;
  localparam int WL_EFF = (WAIT_LONG  < 1) ? 1 : WAIT_LONG;
  localparam int CM1    = (SU_EFF > EH_EFF) ? SU_EFF : EH_EFF;
  localparam int CM2    = (WS_EFF > WL_EFF) ? WS_EFF : WL_EFF;
  localparam int CMAX   = (CM1 > CM2) ? CM1 : CM2;
  localparam int CW     = $clog2(CMAX + 1);
  localparam int PW     = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [2:0] {S_IDLE, S_SETUP, S_PULSE, S_HOLD, S_WAIT} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [PW-1:0]   ptr_q, ptr_d;
  logic [PW-1:0]   owner_q, owner_d;
  logic [PW-1:0]   win;
  logic            win_vld;
  logic            take;
  logic            rs_q, rs_d;
  logic [7:0]      db_q, db_d;
  logic            e_q, e_d;
  logic            busy_q, busy_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic [NREQ-1:0] done_q, done_d;
  logic            long_wait;

  // First asserted request at or after the pointer, wrapping.
  always_comb begin
    win_vld = 1'b0;
    win     = ptr_q;
    for (int k = 0; k < NREQ; k++) begin
      if (!win_vld && req[(int'(ptr_q) + k) % NREQ]) begin
        win_vld = 1'b1;
        win     = PW'((int'(ptr_q) + k) % NREQ);
      end
    end
  end

  assign long_wait = !rs_q && (db_q[7:2] == 6'd0);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    rs_d    = rs_q;
    db_d    = db_q;
    busy_d  = busy_q;
    gnt_d   = '0;
    done_d  = '0;
    take    = 1'b0;
    case (state_q)
      S_IDLE: take = init_done && win_vld;
      S_SETUP: begin
        if (cnt_q == '0) begin
          state_d = S_PULSE;
          cnt_d   = CW'(EH_EFF - 1);
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_PULSE: begin
        if (cnt_q == '0) state_d = S_HOLD;
        else             cnt_d   = cnt_q - 1'b1;
      end
      S_HOLD: begin
        state_d = S_WAIT;
        cnt_d   = long_wait ? CW'(WL_EFF - 1) : CW'(WS_EFF - 1);
      end
      S_WAIT: begin
        // The edge leaving the last wait cycle also arbitrates, so back-to-back writes need no idle gap.
        if (cnt_q == '0) begin
          take = init_done && win_vld;
          if (!take) begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (take) begin
      gnt_d[win] = 1'b1;
      rs_d       = req_rs[win];
      db_d       = req_data[8*int'(win) +: 8];
      busy_d     = 1'b1;
      owner_d    = win;
      state_d    = S_SETUP;
      cnt_d      = CW'(SU_EFF - 1);
      if (int'(win) == NREQ - 1) ptr_d = '0;
      else                       ptr_d = win + PW'(1);
    end

    if (state_d == S_WAIT && cnt_d == '0) done_d[owner_q] = 1'b1;
    e_d = (state_d == S_PULSE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      ptr_q   <= '0;
      owner_q <= '0;
      rs_q    <= 1'b0;
      db_q    <= 8'h00;
      e_q     <= 1'b0;
      busy_q  <= 1'b0;
      gnt_q   <= '0;
      done_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      rs_q    <= rs_d;
      db_q    <= db_d;
      e_q     <= e_d;
      busy_q  <= busy_d;
      gnt_q   <= gnt_d;
      done_q  <= done_d;
    end
  end

  assign gnt  = gnt_q;
  assign done = done_q;
  assign busy = busy_q;
  assign RS   = rs_q;
  assign RW   = 1'b0;
  assign E    = e_q;
  assign DB   = db_q;

endmodule

// File: tb/tb_lcd_bus_arbiter.sv
// Bench for lcd_bus_arbiter: vector table, directed corner sequences, and random traffic vs a timeline model.
module tb_lcd_bus_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        init_done = 1'b0;
  logic [1:0]  req = 2'b00;
  logic [1:0]  req_rs = 2'b00;
  logic [15:0] req_data = 16'h0000;
  logic [1:0]  gnt, done;
  logic        busy, RS, RW, E;
  logic [7:0]  DB;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [1:0]  req;
    logic [1:0]  rs;
    logic [15:0] data;
    logic [1:0]  exp_gnt;
    logic        exp_rs;
    logic [7:0]  exp_db;
    int          exp_done;
  } vec_t;
  vec_t tbl [9];

  // Transaction-level model: offset of the current cycle since its grant.
  bit         m_busy;
  int         m_t, m_own, m_wl, m_ptr, m_win;
  logic       m_rs;
  logic [7:0] m_db;
  bit         m_free;

  lcd_bus_arbiter #(
    .NREQ(2), .SETUP_CYC(1), .E_HIGH_CYC(2), .WAIT_SHORT(4), .WAIT_LONG(160)
  ) dut (
    .clk(clk), .rst(rst), .init_done(init_done), .req(req), .req_rs(req_rs),
    .req_data(req_data), .gnt(gnt), .done(done), .busy(busy), .RS(RS), .RW(RW),
    .E(E), .DB(DB)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (busy && n < 400) begin
      tick();
      n++;
    end
    chk("drain_busy", int'(busy), 0);
  endtask

  initial begin
    int errs, dcyc, dval, gcount, owner;

    tbl[0] = '{2'b01, 2'b01, 16'h0041, 2'b01, 1'b1, 8'h41, 7};
    tbl[1] = '{2'b10, 2'b00, 16'h0100, 2'b10, 1'b0, 8'h01, 163};
    tbl[2] = '{2'b10, 2'b00, 16'h3800, 2'b10, 1'b0, 8'h38, 7};
    tbl[3] = '{2'b01, 2'b00, 16'h0002, 2'b01, 1'b0, 8'h02, 163};
    tbl[4] = '{2'b10, 2'b00, 16'h0300, 2'b10, 1'b0, 8'h03, 163};
    tbl[5] = '{2'b01, 2'b00, 16'h0004, 2'b01, 1'b0, 8'h04, 7};
    tbl[6] = '{2'b11, 2'b01, 16'h0155, 2'b10, 1'b0, 8'h01, 163};
    tbl[7] = '{2'b11, 2'b10, 16'h0200, 2'b01, 1'b0, 8'h00, 163};
    tbl[8] = '{2'b10, 2'b10, 16'h0100, 2'b10, 1'b1, 8'h01, 7};

    // Reset state and init hold-off
    repeat (20) tick();
    chk("rst_gnt", int'(gnt), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_rs", int'(RS), 0);
    chk("rst_rw", int'(RW), 0);
    chk("rst_e", int'(E), 0);
    chk("rst_db", int'(DB), 0);
    rst = 1'b1;
    req = 2'b01; req_rs = 2'b01; req_data = 16'h0041;
    errs = 0;
    repeat (50) begin
      tick();
      if (gnt != 2'b00 || E || busy) errs++;
    end
    chk("holdoff", errs, 0);
    init_done = 1'b1;
    tick();
    chk("holdoff_gnt", int'(gnt), 1);
    req = 2'b00;
    drain();

    // Single writes from the vector table
    for (int i = 0; i < 9; i++) begin
      req = tbl[i].req; req_rs = tbl[i].rs; req_data = tbl[i].data;
      tick();
      chk("tbl_gnt", int'(gnt), int'(tbl[i].exp_gnt));
      chk("tbl_rs", int'(RS), int'(tbl[i].exp_rs));
      chk("tbl_db", int'(DB), int'(tbl[i].exp_db));
      chk("tbl_busy", int'(busy), 1);
      req = 2'b00;
      dcyc = -1; dval = 0; errs = 0;
      for (int off = 1; off <= tbl[i].exp_done + 1; off++) begin
        tick();
        if (E !== (off == 1 || off == 2)) errs++;
        if (gnt !== 2'b00) errs++;
        if (RS !== tbl[i].exp_rs || DB !== tbl[i].exp_db) errs++;
        if (done !== 2'b00 && dcyc < 0) begin
          dcyc = off;
          dval = int'(done);
        end
      end
      chk("tbl_done_cyc", dcyc, tbl[i].exp_done);
      chk("tbl_done_who", dval, int'(tbl[i].exp_gnt));
      chk("tbl_pattern", errs, 0);
      chk("tbl_busy_end", int'(busy), 0);
      drain();
    end

    // init_done falls mid-write: finish it, then no grants until it returns
    req = 2'b01; req_rs = 2'b01; req_data = 16'h6261;
    tick();
    chk("idf_gnt", int'(gnt), 1);
    req = 2'b10; init_done = 1'b0;
    dcyc = -1; dval = 0; gcount = 0;
    for (int off = 1; off <= 40; off++) begin
      tick();
      if (gnt != 2'b00) gcount++;
      if (done != 2'b00 && dcyc < 0) begin
        dcyc = off;
        dval = int'(done);
      end
    end
    chk("idf_done_cyc", dcyc, 7);
    chk("idf_done_who", dval, 1);
    chk("idf_no_gnt", gcount, 0);
    init_done = 1'b1;
    tick();
    chk("idf_regnt", int'(gnt), 2);
    req = 2'b00;
    drain();

    // Reset while E is high, with the pointer moved off 0 beforehand
    req = 2'b01; req_rs = 2'b01; req_data = 16'h0041;
    tick();
    chk("mrst_gnt", int'(gnt), 1);
    req = 2'b00;
    tick();
    chk("mrst_e_hi", int'(E), 1);
    #2;
    rst = 1'b0;
    #1;
    chk("mrst_e", int'(E), 0);
    chk("mrst_busy", int'(busy), 0);
    chk("mrst_gnt0", int'(gnt), 0);
    chk("mrst_done", int'(done), 0);
    req = 2'b11; req_rs = 2'b11; req_data = 16'hB1A0;
    rst = 1'b1;

    // Round-robin with both requests held
    tick();
    for (int c = 0; c < 32; c++) begin
      if (c > 0) tick();
      owner = (c / 8) % 2;
      chk("rr_gnt", int'(gnt), (c % 8 == 0) ? (1 << owner) : 0);
      chk("rr_done", int'(done), (c % 8 == 7) ? (1 << owner) : 0);
      chk("rr_db", int'(DB), owner ? 32'hB1 : 32'hA0);
      chk("rr_e", int'(E), (c % 8 == 1 || c % 8 == 2) ? 1 : 0);
    end
    req = 2'b00;
    drain();

    // Withdrawn request while busy
    req = 2'b01; req_rs = 2'b01; req_data = 16'h7741;
    tick();
    chk("wd_gnt", int'(gnt), 1);
    req = 2'b00;
    gcount = 0;
    for (int off = 1; off <= 30; off++) begin
      tick();
      if (off == 2) req = 2'b10;
      if (off == 4) req = 2'b00;
      if (gnt != 2'b00) gcount++;
    end
    chk("wd_no_gnt", gcount, 0);
    chk("wd_idle", int'(busy), 0);

    // Random traffic against the timeline model
    req = 2'b00;
    rst = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    init_done = 1'b1;
    m_busy = 0; m_t = 0; m_own = 0; m_wl = 4; m_ptr = 0; m_rs = 1'b0; m_db = 8'h00;
    for (int n = 0; n < 2500; n++) begin
      for (int b = 0; b < 2; b++) if ($urandom % 4 == 0) req[b] = ~req[b];
      req_rs = 2'($urandom);
      for (int b = 0; b < 2; b++)
        req_data[8*b +: 8] = ($urandom % 4 == 0) ? 8'($urandom % 4) : 8'($urandom);
      if (init_done) begin
        if ($urandom % 40 == 0) init_done = 1'b0;
      end else if ($urandom % 3 == 0) begin
        init_done = 1'b1;
      end
      m_free = !m_busy || (m_t == 3 + m_wl);
      m_win  = -1;
      if (m_free && init_done)
        for (int k = 0; k < 2; k++)
          if (m_win < 0 && req[(m_ptr + k) % 2]) m_win = (m_ptr + k) % 2;
      tick();
      if (m_win >= 0) begin
        m_busy = 1; m_t = 0; m_own = m_win;
        m_rs   = req_rs[m_win];
        m_db   = req_data[8*m_win +: 8];
        m_wl   = (!m_rs && m_db < 4) ? 160 : 4;
        m_ptr  = (m_win + 1) % 2;
      end else if (m_busy) begin
        if (m_t == 3 + m_wl) m_busy = 0;
        else                 m_t++;
      end
      chk("rnd_gnt", int'(gnt), (m_win >= 0) ? (1 << m_win) : 0);
      chk("rnd_done", int'(done), (m_busy && m_t == 3 + m_wl) ? (1 << m_own) : 0);
      chk("rnd_busy", int'(busy), int'(m_busy));
      chk("rnd_e", int'(E), (m_busy && (m_t == 1 || m_t == 2)) ? 1 : 0);
      chk("rnd_rs", int'(RS), int'(m_rs));
      chk("rnd_db", int'(DB), int'(m_db));
      chk("rnd_rw", int'(RW), 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
